uart_cmd_ctrl: RTL and testbench

//  Frame parser and sequencer between the 8N1 UART byte receiver and the PID configuration registers.

---
 rtl/uart_cmd_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// uart_cmd_ctrl
//
// Frame parser and sequencer that sits between an 8N1 UART byte receiver and
// the PID configuration register file. A host sends 5-byte frames
//   SYNC, ADDR, DATA_HI, DATA_LO, CSUM
// and each valid frame produces a single-cycle register write. CSUM is the
// XOR of ADDR, DATA_HI and DATA_LO. A bad checksum, an out-of-range address
// or an inter-byte timeout rejects the frame. A rejected frame pulses
// frame_err and bumps a saturating error counter.
//
// Parameters
//   SYNC_BYTE    frame start marker
//   NUM_REGS     number of writable registers (valid ADDR is 0..NUM_REGS-1)
//   TIMEOUT_CYC  max clk_in cycles allowed between accepted bytes in a frame
//
// Ports
//   clk_in       in   1   system clock
//   reset        in   1   asynchronous, active-high reset
//   rx_byte      in   8   received byte, valid while rx_rdy is high
//   rx_rdy       in   1   receiver ready level (may be high for many cycles)
//   cfg_wr_en    out  1   one-cycle register write strobe
//   cfg_addr     out  8   write address, held until the next write
//   cfg_wr_data  out  16  write data {DATA_HI, DATA_LO}, held until next write
//   frame_err    out  1   one-cycle pulse on a rejected frame
//   err_cnt      out  8   rejected-frame count, saturates at 8'hFF
//   busy         out  1   high whenever the parser is not idle
// -----------------------------------------------------------------------------
module uart_cmd_ctrl #(
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int unsigned NUM_REGS    = 4,
  parameter logic [15:0] TIMEOUT_CYC = 16'd50000
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic [7:0]  rx_byte,
  input  logic        rx_rdy,
  output logic        cfg_wr_en,
  output logic [7:0]  cfg_addr,
  output logic [15:0] cfg_wr_data,
  output logic        frame_err,
  output logic [7:0]  err_cnt,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DHI,
    S_DLO,
    S_CSUM,
    S_WRITE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        rx_rdy_q;
  logic        accept;
  logic [7:0]  addr_r;
  logic [7:0]  hi_r;
  logic [7:0]  lo_r;
  logic [7:0]  csum_r;
  logic [15:0] tmo_cnt;
  logic        in_frame;
  logic        timeout;
  logic        addr_ok;
  logic        err_evt;
  logic        write_go;

  // Rising edge of the ready level marks one new byte. rx_rdy_q comes out of
  // reset high so a level that is already high at release is not a byte.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) rx_rdy_q <= 1'b1;
    else       rx_rdy_q <= rx_rdy;
  end

  assign accept   = rx_rdy & ~rx_rdy_q;
  assign in_frame = (state == S_ADDR) || (state == S_DHI) ||
                    (state == S_DLO)  || (state == S_CSUM);
  assign timeout  = in_frame && (tmo_cnt == TIMEOUT_CYC);
  assign addr_ok  = (32'(addr_r) < NUM_REGS);
  assign busy     = (state != S_IDLE);
  assign cfg_wr_en = (state == S_WRITE);

  // State register
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic. Inside a frame an accept always takes priority over a
  // timeout landing in the same cycle.
  // NOTE: every output of this block gets a default first so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    err_evt   = 1'b0;
    write_go  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (accept && (rx_byte == SYNC_BYTE)) state_nxt = S_ADDR;
      end
      S_ADDR: begin
        if (accept)       state_nxt = S_DHI;
        else if (timeout) begin state_nxt = S_IDLE; err_evt = 1'b1; end
      end
      S_DHI: begin
        if (accept)       state_nxt = S_DLO;
        else if (timeout) begin state_nxt = S_IDLE; err_evt = 1'b1; end
      end
      S_DLO: begin
        if (accept)       state_nxt = S_CSUM;
        else if (timeout) begin state_nxt = S_IDLE; err_evt = 1'b1; end
      end
      S_CSUM: begin
        if (accept) begin
          if ((rx_byte == csum_r) && addr_ok) begin
            state_nxt = S_WRITE;
            write_go  = 1'b1;
          end else begin
            state_nxt = S_IDLE;
            err_evt   = 1'b1;
          end
        end else if (timeout) begin
          state_nxt = S_IDLE;
          err_evt   = 1'b1;
        end
      end
      // An accept landing in the write cycle is intentionally dropped.
      S_WRITE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Frame field capture and running checksum (SYNC is not part of the sum).
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      addr_r <= '0;
      hi_r   <= '0;
      lo_r   <= '0;
      csum_r <= '0;
    end else if (accept) begin
      case (state)
        S_ADDR: begin addr_r <= rx_byte; csum_r <= rx_byte;          end
        S_DHI:  begin hi_r   <= rx_byte; csum_r <= csum_r ^ rx_byte; end
        S_DLO:  begin lo_r   <= rx_byte; csum_r <= csum_r ^ rx_byte; end
        default: ;
      endcase
    end
  end

  // Inter-byte timeout counter: runs only while a frame is open, clears on
  // every accept, and parks at the limit for the single cycle it is seen.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset)                   tmo_cnt <= '0;
    else if (accept || !in_frame) tmo_cnt <= '0;
    else if (!timeout)           tmo_cnt <= tmo_cnt + 16'd1;
  end

  // Write outputs load as the frame is approved, so they are valid in the
  // strobe cycle and hold until the next successful frame.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      cfg_addr    <= '0;
      cfg_wr_data <= '0;
    end else if (write_go) begin
      cfg_addr    <= addr_r;
      cfg_wr_data <= {hi_r, lo_r};
    end
  end

  // Error pulse and saturating diagnostic counter.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      frame_err <= 1'b0;
      err_cnt   <= '0;
    end else begin
      frame_err <= err_evt;
      if (err_evt && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_cmd_ctrl
//
// Scoreboard bench for uart_cmd_ctrl. The stimulus side drives bytes and feeds
// each one to a frame-level reference model that collects bytes into a list
// and decides write/error outcomes from the frame rules. Expected events
// (write or error, with the cycle they should appear in) are queued; an
// independent monitor pops and compares whenever cfg_wr_en or frame_err is
// seen. A short timeout is used so idle gaps stay cheap.
// -----------------------------------------------------------------------------
module tb_uart_cmd_ctrl;

  localparam logic [7:0] SYNC  = 8'hA5;
  localparam int         NREGS = 4;
  localparam int         TMO   = 300;

  logic        clk_in  = 1'b0;
  logic        reset   = 1'b1;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_rdy  = 1'b0;
  logic        cfg_wr_en;
  logic [7:0]  cfg_addr;
  logic [15:0] cfg_wr_data;
  logic        frame_err;
  logic [7:0]  err_cnt;
  logic        busy;

  uart_cmd_ctrl #(
    .SYNC_BYTE  (SYNC),
    .NUM_REGS   (NREGS),
    .TIMEOUT_CYC(16'(TMO))
  ) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .rx_byte    (rx_byte),
    .rx_rdy     (rx_rdy),
    .cfg_wr_en  (cfg_wr_en),
    .cfg_addr   (cfg_addr),
    .cfg_wr_data(cfg_wr_data),
    .frame_err  (frame_err),
    .err_cnt    (err_cnt),
    .busy       (busy)
  );

  always #5 clk_in = ~clk_in;

  // Cycle number: value after the most recent rising edge.
  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model and scoreboard queue
  // ---------------------------------------------------------------------------
  typedef enum logic {EV_WR, EV_ERR} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    logic [7:0]  addr;
    logic [15:0] data;
    logic [7:0]  cnt;
    int          at;
  } ev_t;

  ev_t        exp_q[$];
  bit         m_in_frame = 1'b0;
  logic [7:0] m_buf[$];
  int         m_last_acc = 0;
  int         m_err = 0;

  task automatic m_error(input int at);
    ev_t e;
    m_err  = (m_err == 255) ? 255 : m_err + 1;
    e.kind = EV_ERR;
    e.addr = '0;
    e.data = '0;
    e.cnt  = 8'(m_err);
    e.at   = at;
    exp_q.push_back(e);
  endtask

  // One accepted byte; 'at' is the cycle number right after its accept edge.
  task automatic m_byte(input logic [7:0] b, input int at);
    ev_t        e;
    logic [7:0] x;
    if (!m_in_frame) begin
      if (b == SYNC) begin
        m_in_frame = 1'b1;
        m_buf.delete();
      end
    end else begin
      m_buf.push_back(b);
      if (m_buf.size() == 4) begin
        x = m_buf[0] ^ m_buf[1] ^ m_buf[2];
        if ((m_buf[3] == x) && (int'(m_buf[0]) < NREGS)) begin
          e.kind = EV_WR;
          e.addr = m_buf[0];
          e.data = {m_buf[1], m_buf[2]};
          e.cnt  = '0;
          e.at   = at;
          exp_q.push_back(e);
        end else begin
          m_error(at);
        end
        m_in_frame = 1'b0;
      end
    end
    m_last_acc = at;
  endtask

  task automatic m_reset();
    m_in_frame = 1'b0;
    m_buf.delete();
    m_err = 0;
    exp_q.delete();
  endtask

  // ---------------------------------------------------------------------------
  // Drivers (entered and left on a falling edge)
  // ---------------------------------------------------------------------------
  task automatic send_byte(input logic [7:0] b, input int h, input int l);
    rx_byte = b;
    rx_rdy  = 1'b1;
    m_byte(b, cyc + 1);
    repeat (h) @(negedge clk_in);
    rx_rdy = 1'b0;
    repeat (l) @(negedge clk_in);
  endtask

  task automatic send5(input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2, input logic [7:0] b3,
                       input logic [7:0] b4, input int h, input int l);
    send_byte(b0, h, l);
    send_byte(b1, h, l);
    send_byte(b2, h, l);
    send_byte(b3, h, l);
    send_byte(b4, h, l);
  endtask

  // Quiet gap. If the next possible accept would come more than TMO+1 cycles
  // after the last one, the open frame times out TMO+1 cycles after it.
  task automatic stall(input int n);
    if (m_in_frame && ((cyc + n + 1) - m_last_acc > TMO + 1)) begin
      m_error(m_last_acc + TMO + 1);
      m_in_frame = 1'b0;
    end
    repeat (n) @(negedge clk_in);
  endtask

  task automatic drain(input string name);
    int budget;
    budget = TMO + 20;
    while ((exp_q.size() != 0) && (budget > 0)) begin
      @(negedge clk_in);
      budget--;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic do_reset(input string name);
    reset = 1'b1;
    m_reset();
    repeat (3) @(negedge clk_in);
    check({name, "_busy"}, busy, 1'b0);
    check({name, "_err_cnt"}, err_cnt, 8'h00);
    check({name, "_frame_err"}, frame_err, 1'b0);
    check({name, "_wr_en"}, cfg_wr_en, 1'b0);
    reset = 1'b0;
    @(negedge clk_in);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  always @(negedge clk_in) begin
    ev_t e;
    if (!reset && (cfg_wr_en || frame_err)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_wr_en", cfg_wr_en, 1'b0);
        check("unexpected_frame_err", frame_err, 1'b0);
      end else begin
        e = exp_q.pop_front();
        if (e.kind == EV_WR) begin
          check("wr_en", cfg_wr_en, 1'b1);
          check("wr_addr", cfg_addr, e.addr);
          check("wr_data", cfg_wr_data, e.data);
          check("wr_cycle", cyc, e.at);
          check("wr_no_err", frame_err, 1'b0);
        end else begin
          check("frame_err", frame_err, 1'b1);
          check("err_cnt", err_cnt, e.cnt);
          check("err_cycle", cyc, e.at);
          check("err_no_wr", cfg_wr_en, 1'b0);
        end
      end
    end
  end

  // Watchdog: the run is far shorter than this.
  initial begin
    #800us;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [7:0] a, hi, lo, cs;

    repeat (3) @(negedge clk_in);
    check("rst_busy", busy, 1'b0);
    check("rst_wr_en", cfg_wr_en, 1'b0);
    check("rst_addr", cfg_addr, 8'h00);
    check("rst_data", cfg_wr_data, 16'h0000);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_err_cnt", err_cnt, 8'h00);
    reset = 1'b0;
    @(negedge clk_in);

    // Valid frame with long ready pulses.
    send5(SYNC, 8'h02, 8'h12, 8'h34, 8'h24, 20, 4);
    drain("t1_drain");
    check("t1_addr_hold", cfg_addr, 8'h02);
    check("t1_data_hold", cfg_wr_data, 16'h1234);

    // Bad checksum.
    send5(SYNC, 8'h02, 8'h12, 8'h34, 8'h25, 3, 2);
    drain("t2_drain");
    check("t2_busy", busy, 1'b0);
    check("t2_err_cnt", err_cnt, 8'h01);
    check("t2_addr_kept", cfg_addr, 8'h02);

    // Address out of range with a correct checksum.
    send5(SYNC, 8'h04, 8'h00, 8'h01, 8'h05, 2, 2);
    drain("t3_drain");
    check("t3_err_cnt", err_cnt, 8'h02);

    // Timeout after ADDR, then a clean frame.
    send_byte(SYNC, 2, 2);
    send_byte(8'h01, 2, 2);
    check("t4_busy_open", busy, 1'b1);
    stall(TMO + 10);
    check("t4_busy_after_tmo", busy, 1'b0);
    send5(SYNC, 8'h01, 8'h00, 8'h0A, 8'h0B, 2, 2);
    drain("t4_drain");

    // Leading garbage is ignored.
    send_byte(8'h00, 2, 2);
    send_byte(8'hFF, 2, 2);
    send5(SYNC, 8'h03, 8'h80, 8'h00, 8'h83, 2, 2);
    drain("t5_drain");

    // Timeout boundary: gap of TMO+1 cycles survives, TMO+2 does not.
    send_byte(SYNC, 2, 2);
    send_byte(8'h01, 2, 2);
    stall(TMO + 1 - 4);
    send_byte(8'h55, 2, 2);
    send_byte(8'hAA, 2, 2);
    send_byte(8'h01 ^ 8'h55 ^ 8'hAA, 2, 2);
    drain("tb_gap_ok");
    send_byte(SYNC, 2, 2);
    send_byte(8'h01, 2, 2);
    stall(TMO + 2 - 4);
    send_byte(8'h00, 2, 2);
    send_byte(8'h0A, 2, 2);
    send_byte(8'h0B, 2, 2);
    drain("tb_gap_late");

    // Randomized frames: random corruption, garbage and idle gaps.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(3, 0) == 0) send_byte(8'($urandom), 1, 1);
      a  = 8'($urandom_range(5, 0));
      hi = 8'($urandom);
      lo = 8'($urandom);
      cs = a ^ hi ^ lo;
      if ($urandom_range(3, 0) == 0) cs = cs ^ 8'(1 << $urandom_range(7, 0));
      send_byte(SYNC, $urandom_range(4, 1), $urandom_range(4, 1));
      send_byte(a, $urandom_range(4, 1), $urandom_range(4, 1));
      if ($urandom_range(4, 0) == 0) stall($urandom_range(TMO + 4, TMO - 12));
      send_byte(hi, $urandom_range(4, 1), $urandom_range(4, 1));
      send_byte(lo, $urandom_range(4, 1), $urandom_range(4, 1));
      send_byte(cs, $urandom_range(4, 1), $urandom_range(4, 1));
    end
    drain("rand_drain");

    // Reset in the middle of a frame.
    send_byte(SYNC, 2, 2);
    send_byte(8'h01, 2, 2);
    check("mid_busy_before", busy, 1'b1);
    do_reset("mid_rst");
    send5(SYNC, 8'h00, 8'hBE, 8'hEF, 8'h00 ^ 8'hBE ^ 8'hEF, 2, 2);
    drain("mid_after_drain");

    // Saturation of the error counter.
    for (int i = 0; i < 256; i++) begin
      a = 8'($urandom_range(3, 0));
      send5(SYNC, a, 8'h11, 8'h22, (a ^ 8'h11 ^ 8'h22) ^ 8'h01, 1, 1);
    end
    drain("sat_drain");
    check("sat_err_cnt", err_cnt, 8'hFF);
    send5(SYNC, 8'h02, 8'h00, 8'h00, 8'h00, 1, 1);
    drain("sat_hold_drain");
    check("sat_err_cnt_hold", err_cnt, 8'hFF);

    // Ready already high across reset release must not count as a byte.
    rx_byte = SYNC;
    rx_rdy  = 1'b1;
    reset   = 1'b1;
    m_reset();
    repeat (2) @(negedge clk_in);
    reset = 1'b0;
    repeat (5) @(negedge clk_in);
    check("hi_rdy_busy", busy, 1'b0);
    check("hi_rdy_err_cnt", err_cnt, 8'h00);
    rx_rdy = 1'b0;
    @(negedge clk_in);
    send_byte(8'h02, 2, 2);
    send_byte(8'h12, 2, 2);
    send_byte(8'h34, 2, 2);
    send_byte(8'h24, 2, 2);
    repeat (5) @(negedge clk_in);
    check("hi_rdy_busy_after", busy, 1'b0);
    send5(SYNC, 8'h03, 8'h12, 8'h34, 8'h03 ^ 8'h12 ^ 8'h34, 2, 2);
    drain("final_drain");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
